// File: rtl/multi_message_printer_pkg.sv
// Shared types and character constants for the UART message printer.
package multi_message_printer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  localparam logic [7:0] NUL_CHAR = 8'h00;
  localparam logic [7:0] ESC_CHAR = 8'h1B;

endpackage

// File: rtl/multi_message_printer_if.sv
// Serial-path signals between uart_rx/uart_tx and the message printer.
interface multi_message_printer_if;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       busy;
  logic       msg_done;

  modport master (
    output rx_data, new_rx_data, tx_busy,
    input  tx_data, new_tx_data, busy, msg_done
  );

  modport slave (
    input  rx_data, new_rx_data, tx_busy,
    output tx_data, new_tx_data, busy, msg_done
  );
endinterface

// File: rtl/multi_message_printer_rom.sv
// Case-based message ROM with a one-cycle registered read; unused slots read as NUL.
module message_bank_rom
  import multi_message_printer_pkg::*;
#(
  parameter int MSG_COUNT   = 4,
  parameter int MSG_MAX_LEN = 16,
  parameter int ADDR_W      = $clog2(MSG_COUNT * MSG_MAX_LEN)
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  int         msg_idx;
  int         chr;
  logic [7:0] rom_d;

  always_comb begin
    msg_idx = int'(addr) / MSG_MAX_LEN;
    chr     = int'(addr) % MSG_MAX_LEN;
    rom_d   = NUL_CHAR;
    case (msg_idx)
      // Message 0 fills all 16 slots with no terminator.
      0: case (chr)
        0: rom_d = "0";   1: rom_d = "1";   2: rom_d = "2";   3: rom_d = "3";
        4: rom_d = "4";   5: rom_d = "5";   6: rom_d = "6";   7: rom_d = "7";
        8: rom_d = "8";   9: rom_d = "9";  10: rom_d = "A";  11: rom_d = "B";
       12: rom_d = "C";  13: rom_d = "D";  14: rom_d = "E";  15: rom_d = "F";
        default: rom_d = NUL_CHAR;
      endcase
      1: case (chr)
        0: rom_d = "H";   1: rom_d = "i";   2: rom_d = 8'h0A;
        default: rom_d = NUL_CHAR;
      endcase
      2: case (chr)
        0: rom_d = "A";   1: rom_d = "B";   2: rom_d = "C";   3: rom_d = "D";
        4: rom_d = "E";   5: rom_d = "F";   6: rom_d = "G";
        default: rom_d = NUL_CHAR;
      endcase
      3: case (chr)
        0: rom_d = "O";   1: rom_d = "K";
        default: rom_d = NUL_CHAR;
      endcase
      default: rom_d = NUL_CHAR;
    endcase
  end

  always_ff @(posedge clk) begin
    data <= rom_d;
  end

endmodule

// File: rtl/multi_message_printer.sv
// Trigger-selected UART message printer: streams one ROM message per trigger byte,
// stops at NUL or after MSG_MAX_LEN bytes, and aborts on ABORT_CHAR.
module multi_message_printer
  import multi_message_printer_pkg::*;
#(
  parameter int         MSG_COUNT   = 4,
  parameter int         MSG_MAX_LEN = 16,
  parameter logic [7:0] TRIG_BASE   = 8'h30,
  parameter logic [7:0] ABORT_CHAR  = ESC_CHAR
) (
  input  logic                   clk,
  input  logic                   rst,
  multi_message_printer_if.slave bus
);

  localparam int ADDR_W   = $clog2(MSG_COUNT * MSG_MAX_LEN);
  localparam int MSG_W    = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1;
  localparam int CHAR_W   = $clog2(MSG_MAX_LEN);
  localparam int TRIG_LIM = int'(TRIG_BASE) + MSG_COUNT;

  state_e            state_q, state_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d;
  logic              done;
  logic              trig;
  logic              abort;
  logic              last_char;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  // Integer compare keeps the trigger window from wrapping past 8'hFF.
  assign trig      = bus.new_rx_data && (int'(bus.rx_data) >= int'(TRIG_BASE))
                                     && (int'(bus.rx_data) < TRIG_LIM);
  assign abort     = bus.new_rx_data && (bus.rx_data == ABORT_CHAR);
  assign last_char = (int'(char_q) == MSG_MAX_LEN - 1);
  assign rom_addr  = ADDR_W'(int'(msg_q) * MSG_MAX_LEN + int'(char_q));

  message_bank_rom #(
    .MSG_COUNT   (MSG_COUNT),
    .MSG_MAX_LEN (MSG_MAX_LEN)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    char_d    = char_q;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        char_d = '0;
        if (trig) begin
          msg_d   = MSG_W'(int'(bus.rx_data) - int'(TRIG_BASE));
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = abort ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        // Abort outranks both termination and a pending byte.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rom_data == NUL_CHAR) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end else if (!bus.tx_busy) begin
          tx_data_d = rom_data;
          new_tx_d  = 1'b1;
          if (last_char) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            char_d  = char_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      msg_q     <= '0;
      char_q    <= '0;
      tx_data_q <= 8'h00;
      new_tx_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      char_q    <= char_d;
      tx_data_q <= tx_data_d;
      new_tx_q  <= new_tx_d;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.new_tx_data = new_tx_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.msg_done    = done && !rst;

endmodule

// File: tb/tb_multi_message_printer.sv
// Directed bench for multi_message_printer: per-cycle stimulus/expectation plans.
module tb_multi_message_printer;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multi_message_printer_if ifc ();

  multi_message_printer dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Plan: inputs driven during cycle c, expectations observed at cycle c.
  logic       p_vld [64];
  logic [7:0] p_rx  [64];
  logic       p_txb [64];
  logic       p_rst [64];
  logic       e_stb [64];
  logic [7:0] e_dat [64];
  logic       e_done[64];
  logic       e_busy[64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) begin
      p_vld[i] = 1'b0; p_rx[i] = 8'h00; p_txb[i] = 1'b0; p_rst[i] = 1'b0;
      e_stb[i] = 1'b0; e_dat[i] = 8'h00; e_done[i] = 1'b0; e_busy[i] = 1'b0;
    end
  endtask

  task automatic trig_at(input int c, input logic [7:0] b);
    p_vld[c] = 1'b1;
    p_rx[c]  = b;
  endtask

  task automatic stb_at(input int c, input logic [7:0] d);
    e_stb[c] = 1'b1;
    e_dat[c] = d;
  endtask

  task automatic busy_span(input int a, input int b);
    for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
  endtask

  task automatic run_plan(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      ifc.rx_data     = p_rx[c];
      ifc.new_rx_data = p_vld[c];
      ifc.tx_busy     = p_txb[c];
      rst             = p_rst[c];
      @(negedge clk);
      chk($sformatf("%s.stb@%0d", tag, c + 1), ifc.new_tx_data, e_stb[c + 1]);
      if (e_stb[c + 1])
        chk($sformatf("%s.dat@%0d", tag, c + 1), ifc.tx_data, e_dat[c + 1]);
      chk($sformatf("%s.done@%0d", tag, c + 1), ifc.msg_done, e_done[c + 1]);
      chk($sformatf("%s.busy@%0d", tag, c + 1), ifc.busy, e_busy[c + 1]);
    end
    ifc.rx_data     = 8'h00;
    ifc.new_rx_data = 1'b0;
    ifc.tx_busy     = 1'b0;
    rst             = 1'b0;
  endtask

  initial begin
    string s0;
    s0 = "0123456789ABCDEF";
    rst             = 1'b1;
    ifc.rx_data     = 8'h00;
    ifc.new_rx_data = 1'b0;
    ifc.tx_busy     = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.tx_data", ifc.tx_data, 8'h00);
    chk("rst.new_tx",  ifc.new_tx_data, 1'b0);
    chk("rst.busy",    ifc.busy, 1'b0);
    chk("rst.done",    ifc.msg_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // "1" -> "Hi\n": bytes at +3/+5/+7, done at +8.
    clear_plan();
    trig_at(0, 8'h31);
    stb_at(3, 8'h48); stb_at(5, 8'h69); stb_at(7, 8'h0A);
    e_done[8] = 1'b1;
    busy_span(1, 8);
    run_plan("msg1", 10);

    // "0" -> 16 bytes, no terminator; done flagged while the 16th is issued.
    clear_plan();
    trig_at(0, 8'h30);
    for (int k = 0; k < 16; k++) stb_at(3 + 2 * k, s0[k]);
    e_done[32] = 1'b1;
    busy_span(1, 32);
    run_plan("full", 36);

    // tx_busy high for 10 cycles right after the first byte.
    clear_plan();
    trig_at(0, 8'h31);
    for (int i = 3; i <= 12; i++) p_txb[i] = 1'b1;
    stb_at(3, 8'h48); stb_at(14, 8'h69); stb_at(16, 8'h0A);
    e_done[17] = 1'b1;
    busy_span(1, 17);
    run_plan("txbusy", 19);

    // ESC after two bytes of "ABCDEFG".
    clear_plan();
    trig_at(0, 8'h32);
    stb_at(3, 8'h41); stb_at(5, 8'h42);
    trig_at(5, 8'h1B);
    busy_span(1, 5);
    run_plan("abort", 12);

    // ESC in SEND with tx_busy low: abort beats the send.
    clear_plan();
    trig_at(0, 8'h32);
    trig_at(2, 8'h1B);
    busy_span(1, 2);
    run_plan("abortsend", 6);

    // Ignored in IDLE: "9", first out-of-range "4", ESC, one below base "/".
    clear_plan();
    trig_at(0, 8'h39); trig_at(2, 8'h34); trig_at(4, 8'h1B); trig_at(6, 8'h2F);
    run_plan("ignore", 9);

    // Triggers mid-message do not disturb the current message.
    clear_plan();
    trig_at(0, 8'h31);
    trig_at(2, 8'h32); trig_at(4, 8'h30);
    stb_at(3, 8'h48); stb_at(5, 8'h69); stb_at(7, 8'h0A);
    e_done[8] = 1'b1;
    busy_span(1, 8);
    run_plan("midtrig", 10);

    // Highest valid trigger "3" -> "OK".
    clear_plan();
    trig_at(0, 8'h33);
    stb_at(3, 8'h4F); stb_at(5, 8'h4B);
    e_done[6] = 1'b1;
    busy_span(1, 6);
    run_plan("msg3", 8);

    // Reset in SEND cuts the message before the second byte.
    clear_plan();
    trig_at(0, 8'h30);
    stb_at(3, 8'h30);
    p_rst[4] = 1'b1;
    busy_span(1, 4);
    run_plan("midrst", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
